sub_serial_64: RTL and testbench

- Multi-cycle subtractor: computes A - B - borrow_in over WIDTH/SLICE cycles, one SLICE-bit chunk per cycle.
- Sits beside the adder family in the datapath as the subtract direction of the same arithmetic interface.
- Trades latency for area: one SLICE-wide borrow-lookahead slice is reused every cycle.
- Valid/ready handshake on both the input and output sides; one operation in flight at a time.

---
 rtl/sub_serial_64.sv | 157 +++++++++++++++
 tb/tb_sub_serial_64.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial_64.sv
`default_nettype none
// sub_serial_64: multi-cycle subtractor, one SLICE-bit borrow-lookahead slice per cycle.
// Optional macro SUB_SERIAL_FLAGS_EN adds registered zero/neg result flags.
module sub_serial_64 #(
   parameter int WIDTH = 64,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
`ifdef SUB_SERIAL_FLAGS_EN
   ,
   output logic             zero,
   output logic             neg
`endif
);

   localparam int N   = WIDTH / SLICE;
   localparam int CW  = (N > 1) ? $clog2(N) : 1;
   localparam int LOG = $clog2(SLICE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r, b_r, diff_r;
   logic             carry, bout_r, ovf_r;
   logic             last;

   logic [SLICE-1:0] sa, sb, g0, p0, g, p, gn, pn, sum;
   logic [SLICE:0]   c;
   logic             cout;

   assign last = (cnt == CW'(N - 1));

   // Subtraction as a + ~b with the carry chain seeded by ~bin; the slice
   // carries are built by a Kogge-Stone prefix over generate/propagate.
   always_comb begin
      sa = a_r[cnt*SLICE +: SLICE];
      sb = ~b_r[cnt*SLICE +: SLICE];
      g0 = sa & sb;
      p0 = sa ^ sb;
      g  = g0;
      p  = p0;
      gn = g0;
      pn = p0;
      for (int s = 0; s < LOG; s++) begin
         gn = g;
         pn = p;
         for (int i = 0; i < SLICE; i++) begin
            if (i >= (1 << s)) begin
               gn[i] = g[i] | (p[i] & g[i - (1 << s)]);
               pn[i] = p[i] & p[i - (1 << s)];
            end
         end
         g = gn;
         p = pn;
      end
      c[0] = carry;
      for (int i = 0; i < SLICE; i++) begin
         c[i+1] = g[i] | (p[i] & carry);
      end
      sum  = p0 ^ c[SLICE-1:0];
      cout = c[SLICE];
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = BUSY;
         end
         BUSY: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         carry  <= 1'b0;
         diff_r <= '0;
         bout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r   <= a;
                  b_r   <= b;
                  carry <= ~bin;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               diff_r[cnt*SLICE +: SLICE] <= sum;
               carry <= cout;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  bout_r <= ~cout;
                  ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sum[SLICE-1] != a_r[WIDTH-1]);
               end
            end
            default: ;
         endcase
      end
   end

   assign diff = diff_r;
   assign bout = bout_r;
   assign ovf  = ovf_r;

`ifdef SUB_SERIAL_FLAGS_EN
   logic zero_r, neg_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero_r <= 1'b0;
         neg_r  <= 1'b0;
      end else if (state == BUSY) begin
         zero_r <= ((cnt == '0) ? 1'b1 : zero_r) & (sum == '0);
         if (last) neg_r <= sum[SLICE-1];
      end
   end

   assign zero = zero_r;
   assign neg  = neg_r;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sub_serial_64.sv
`default_nettype none
// tb_sub_serial_64: directed self-checking bench for sub_serial_64 (WIDTH=64, SLICE=8).
module tb_sub_serial_64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a, b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] diff;
   logic        bout;
   logic        ovf;
`ifdef SUB_SERIAL_FLAGS_EN
   logic        zero, neg;
`endif

   int passed = 0;
   int total  = 0;

   sub_serial_64 #(.WIDTH(64), .SLICE(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
`ifdef SUB_SERIAL_FLAGS_EN
      ,
      .zero      (zero),
      .neg       (neg)
`endif
   );

   always #5 clk = ~clk;

   // Called #1 after an edge with the DUT idle; returns edges from accept to out_valid.
   task automatic do_op(input logic [63:0] av, input logic [63:0] bv, input logic bi,
                        output int lat);
      a = av;
      b = bv;
      bin = bi;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
      total++; if (diff !== 64'd0) $display("FAIL reset_diff got=%h exp=0", diff); else passed++;
      total++; if ({bout, ovf} !== 2'b00) $display("FAIL reset_bout_ovf got=%b exp=00", {bout, ovf}); else passed++;
`ifdef SUB_SERIAL_FLAGS_EN
      total++; if ({zero, neg} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {zero, neg}); else passed++;
`endif
   endtask

   task automatic test_basic();
      int lat;
      do_op(64'd10, 64'd3, 1'b0, lat);
      total++; if (lat !== 8) $display("FAIL basic_latency got=%0d exp=8", lat); else passed++;
      total++; if (diff !== 64'd7) $display("FAIL basic_diff got=%h exp=7", diff); else passed++;
      total++; if ({bout, ovf} !== 2'b00) $display("FAIL basic_bout_ovf got=%b exp=00", {bout, ovf}); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_done got=%b exp=0", in_ready); else passed++;
      consume();
      total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL basic_consume got=%b exp=01", {out_valid, in_ready}); else passed++;
      total++; if (diff !== 64'd7) $display("FAIL basic_diff_hold got=%h exp=7", diff); else passed++;
   endtask

   task automatic test_borrow_chain();
      int lat;
      do_op(64'd0, 64'd1, 1'b0, lat);
      total++; if (lat !== 8) $display("FAIL chain_latency got=%0d exp=8", lat); else passed++;
      total++; if (diff !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL chain_diff got=%h exp=ffffffffffffffff", diff); else passed++;
      total++; if ({bout, ovf} !== 2'b10) $display("FAIL chain_bout_ovf got=%b exp=10", {bout, ovf}); else passed++;
      consume();
   endtask

   task automatic test_overflow();
      int lat;
      do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, lat);
      total++; if (diff !== 64'h7FFF_FFFF_FFFF_FFFF) $display("FAIL ovf_diff got=%h exp=7fffffffffffffff", diff); else passed++;
      total++; if ({bout, ovf} !== 2'b01) $display("FAIL ovf_bout_ovf got=%b exp=01", {bout, ovf}); else passed++;
      consume();
   endtask

   task automatic test_equal_operands();
      int lat;
      do_op(64'd5, 64'd5, 1'b1, lat);
      total++; if (diff !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL eq_bin1_diff got=%h exp=ffffffffffffffff", diff); else passed++;
      total++; if ({bout, ovf} !== 2'b10) $display("FAIL eq_bin1_bout_ovf got=%b exp=10", {bout, ovf}); else passed++;
`ifdef SUB_SERIAL_FLAGS_EN
      total++; if ({zero, neg} !== 2'b01) $display("FAIL eq_bin1_flags got=%b exp=01", {zero, neg}); else passed++;
`endif
      consume();
      do_op(64'd5, 64'd5, 1'b0, lat);
      total++; if (diff !== 64'd0) $display("FAIL eq_bin0_diff got=%h exp=0", diff); else passed++;
      total++; if (bout !== 1'b0) $display("FAIL eq_bin0_bout got=%b exp=0", bout); else passed++;
`ifdef SUB_SERIAL_FLAGS_EN
      total++; if ({zero, neg} !== 2'b10) $display("FAIL eq_bin0_flags got=%b exp=10", {zero, neg}); else passed++;
`endif
      consume();
   endtask

   task automatic test_backpressure();
      int lat;
      do_op(64'd100, 64'd1, 1'b0, lat);
      total++; if (lat !== 8) $display("FAIL bp_latency got=%0d exp=8", lat); else passed++;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0] ? 1'b0 : 1'b1;
         a = 64'd1000 + 64'(i);
         b = 64'd7;
         @(posedge clk); #1;
         total++;
         if ({out_valid, in_ready, bout, ovf} !== 4'b1000 || diff !== 64'd99)
            $display("FAIL bp_hold_%0d got=v%b r%b bo%b ov%b d=%h exp=v1 r0 bo0 ov0 d=63", i,
                     out_valid, in_ready, bout, ovf, diff);
         else passed++;
      end
      in_valid = 1'b0;
      consume();
      total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release got=%b exp=01", {out_valid, in_ready}); else passed++;
      total++; if (diff !== 64'd99) $display("FAIL bp_diff_after got=%h exp=63", diff); else passed++;
   endtask

   task automatic test_reset_in_busy();
      int lat;
      a = 64'h1234; b = 64'd1; bin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL busy_reset_hs got=%b exp=10", {in_ready, out_valid}); else passed++;
      total++; if (diff !== 64'd0) $display("FAIL busy_reset_diff got=%h exp=0", diff); else passed++;
      repeat (10) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL busy_reset_no_result got=%b exp=0", out_valid); else passed++;
      do_op(64'd2, 64'd1, 1'b0, lat);
      total++; if (lat !== 8) $display("FAIL after_reset_latency got=%0d exp=8", lat); else passed++;
      total++; if (diff !== 64'd1) $display("FAIL after_reset_diff got=%h exp=1", diff); else passed++;
      consume();
   endtask

   task automatic test_reset_with_valid();
      a = 64'd9; b = 64'd4; bin = 1'b0;
      in_valid = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_wins_in_ready got=%b exp=1", in_ready); else passed++;
      repeat (10) @(posedge clk);
      #1;
      total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL rst_wins_no_op got=%b exp=01", {out_valid, in_ready}); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_borrow_chain();
      test_overflow();
      test_equal_operands();
      test_backpressure();
      test_reset_in_busy();
      test_reset_with_valid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
